// File: rtl/uart_out_sched_pkg.sv
// Shared types and default sizing for the CPU OUT byte scheduler feeding uart_tx.
package uart_out_sched_pkg;

  localparam int unsigned DEFAULT_DEPTH        = 16;
  localparam int unsigned DEFAULT_BUSY_TIMEOUT = 4;
  localparam int unsigned DATA_W               = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; head word is visible without a pop.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push, do_pop;

  // Guard both ends so a stray request can never corrupt pointers or level.
  assign do_push = push_i && (level_q != LW'(DEPTH));
  assign do_pop  = pop_i && (level_q != '0);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign level_o    = level_q;

endmodule

// File: rtl/uart_out_sched.sv
// Buffers CPU OUT bytes and hands them one at a time to uart_tx using a start/busy handshake.
module uart_out_sched
  import uart_out_sched_pkg::*;
#(
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   idle,
  output logic                   ovf,
  output logic                   tmo
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned CW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              ovf_q, ovf_d;
  logic              tmo_q, tmo_d;
  logic              idle_q, idle_d;

  logic              push, pop;
  logic [DATA_W-1:0] fifo_head;
  logic [LW-1:0]     fifo_level;
  logic [LW-1:0]     level_next;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (in_data),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .level_o     (fifo_level)
  );

  assign in_ready = (fifo_level != LW'(DEPTH));
  assign push     = in_valid && in_ready;

  // Handshake FSM: pop in IDLE, pulse start, wait for busy to rise then fall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    tmo_d     = tmo_q;
    pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((fifo_level != '0) && !tx_busy) begin
          pop       = 1'b1;
          tx_data_d = fifo_head;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ovf_d      = ovf_q || (in_valid && !in_ready);
    level_next = fifo_level + LW'(push) - LW'(pop);
    idle_d     = (level_next == '0) && (state_d == ST_IDLE);
    tx_start_d = (state_d == ST_START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      idle_q     <= idle_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign level    = fifo_level;
  assign idle     = idle_q;
  assign ovf      = ovf_q;
  assign tmo      = tmo_q;

endmodule

// File: tb/tb_uart_out_sched.sv
// Directed bench for uart_out_sched with a simple uart_tx busy model and a transmit log.
module tb_uart_out_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [4:0] level;
  logic       idle, ovf, tmo;

  int checks = 0;
  int failures = 0;

  logic       hold_busy = 1'b0;
  logic       no_busy = 1'b0;
  int         busy_len = 10;
  int         busy_cnt = 0;
  int         start_cnt = 0;
  logic [7:0] tx_log[$];

  always #5 clk = ~clk;

  uart_out_sched #(.DEPTH(16), .BUSY_TIMEOUT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .level    (level),
    .idle     (idle),
    .ovf      (ovf),
    .tmo      (tmo)
  );

  // uart_tx model: busy rises the cycle after start and stays for busy_len cycles.
  assign tx_busy = hold_busy || (busy_cnt != 0);

  always @(posedge clk) begin
    if (tx_start) begin
      tx_log.push_back(tx_data);
      start_cnt <= start_cnt + 1;
    end
    if (tx_start && !no_busy) busy_cnt <= busy_len;
    else if (busy_cnt != 0)   busy_cnt <= busy_cnt - 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (12) @(posedge clk);
    #1 rst = 1'b0;
    tx_log.delete();
  endtask

  task automatic push_one(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (!(idle && !tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_idle_wait: got idle=%0b after %0d cycles, want idle=1", name, idle, budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (level !== 5'd0)     begin failures++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (idle !== 1'b1)      begin failures++; $display("FAIL reset_idle: got %b want 1", idle); end
    checks++; if (ovf !== 1'b0)       begin failures++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++; if (tmo !== 1'b0)       begin failures++; $display("FAIL reset_tmo: got %b want 0", tmo); end
    checks++; if (tx_start !== 1'b0)  begin failures++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    checks++; if (tx_data !== 8'h00)  begin failures++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
  endtask

  task automatic test_single();
    int s0;
    do_reset();
    busy_len = 10;
    s0 = start_cnt;
    push_one(8'h41);
    @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_no_early_start: got %b want 0", tx_start); end
    checks++; if (level !== 5'd1)    begin failures++; $display("FAIL single_level_after_push: got %0d want 1", level); end
    checks++; if (idle !== 1'b0)     begin failures++; $display("FAIL single_not_idle: got %b want 0", idle); end
    @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL single_start_latency: got %b want 1", tx_start); end
    checks++; if (tx_data !== 8'h41) begin failures++; $display("FAIL single_tx_data: got %h want 41", tx_data); end
    checks++; if (level !== 5'd0)    begin failures++; $display("FAIL single_level_after_pop: got %0d want 0", level); end
    @(negedge clk);
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_start_one_cycle: got %b want 0", tx_start); end
    wait_idle(40, "single");
    checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL single_start_count: got %0d want 1", start_cnt - s0); end
    checks++; if (tx_data !== 8'h41)    begin failures++; $display("FAIL single_tx_data_hold: got %h want 41", tx_data); end
  endtask

  task automatic test_fill_ovf();
    logic [7:0] got;
    logic       saw_ff;
    do_reset();
    busy_len = 10;
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'(i);
    end
    @(negedge clk);
    checks++; if (level !== 5'd16)   begin failures++; $display("FAIL fill_level: got %0d want 16", level); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
    checks++; if (ovf !== 1'b0)      begin failures++; $display("FAIL fill_ovf_clear: got %b want 0", ovf); end
    in_data = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (ovf !== 1'b1)      begin failures++; $display("FAIL ovf_set: got %b want 1", ovf); end
    checks++; if (level !== 5'd16)   begin failures++; $display("FAIL ovf_level: got %0d want 16", level); end
    hold_busy = 1'b0;
    wait_idle(600, "fill");
    checks++; if (tx_log.size() != 16) begin failures++; $display("FAIL fill_count: got %0d want 16", tx_log.size()); end
    saw_ff = 1'b0;
    for (int i = 0; i < 16; i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      checks++; if (got !== 8'(i)) begin failures++; $display("FAIL fill_order[%0d]: got %h want %h", i, got, 8'(i)); end
    end
    foreach (tx_log[j]) if (tx_log[j] == 8'hFF) saw_ff = 1'b1;
    checks++; if (saw_ff !== 1'b0) begin failures++; $display("FAIL ovf_byte_dropped: got FF transmitted want never"); end
    checks++; if (ovf !== 1'b1)    begin failures++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_stream();
    logic [7:0] exp_q[$];
    logic [7:0] got;
    int n = 0;
    int cyc = 0;
    do_reset();
    busy_len = 1;
    while (n < 40 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (in_ready) begin
        in_valid = 1'b1;
        in_data = 8'(n * 37 + 5);
        exp_q.push_back(8'(n * 37 + 5));
        n++;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (n != 40) begin failures++; $display("FAIL stream_push_budget: got %0d pushed want 40", n); end
    wait_idle(600, "stream");
    checks++; if (tx_log.size() != 40) begin failures++; $display("FAIL stream_count: got %0d want 40", tx_log.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL stream_order[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
    checks++; if (ovf !== 1'b0)   begin failures++; $display("FAIL stream_ovf: got %b want 0", ovf); end
    checks++; if (level !== 5'd0) begin failures++; $display("FAIL stream_level: got %0d want 0", level); end
    busy_len = 10;
  endtask

  task automatic test_timeout();
    logic [7:0] got;
    do_reset();
    busy_len = 10;
    no_busy = 1'b1;
    push_one(8'hA5);
    repeat (2) @(negedge clk);
    checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL tmo_start: got %b want 1", tx_start); end
    repeat (4) @(negedge clk);
    checks++; if (tmo !== 1'b0)  begin failures++; $display("FAIL tmo_early: got %b want 0", tmo); end
    @(negedge clk);
    checks++; if (tmo !== 1'b1)  begin failures++; $display("FAIL tmo_set: got %b want 1", tmo); end
    checks++; if (idle !== 1'b1) begin failures++; $display("FAIL tmo_back_idle: got %b want 1", idle); end
    no_busy = 1'b0;
    push_one(8'h5A);
    wait_idle(60, "tmo");
    got = (tx_log.size() > 1) ? tx_log[1] : 8'hxx;
    checks++; if (tx_log.size() != 2) begin failures++; $display("FAIL tmo_count: got %0d want 2", tx_log.size()); end
    checks++; if (got !== 8'h5A)      begin failures++; $display("FAIL tmo_next_byte: got %h want 5A", got); end
    checks++; if (tmo !== 1'b1)       begin failures++; $display("FAIL tmo_sticky: got %b want 1", tmo); end
  endtask

  task automatic test_reset_mid();
    int s0;
    do_reset();
    busy_len = 10;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'hB0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      in_data = 8'hB0 + 8'(i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (level !== 5'd5)    begin failures++; $display("FAIL mid_level_before: got %0d want 5", level); end
    checks++; if (tx_busy !== 1'b1)  begin failures++; $display("FAIL mid_busy_before: got %b want 1", tx_busy); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    s0 = start_cnt;
    @(negedge clk);
    checks++; if (level !== 5'd0)    begin failures++; $display("FAIL mid_level: got %0d want 0", level); end
    checks++; if (idle !== 1'b1)     begin failures++; $display("FAIL mid_idle: got %b want 1", idle); end
    checks++; if (ovf !== 1'b0)      begin failures++; $display("FAIL mid_ovf: got %b want 0", ovf); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL mid_tx_data: got %h want 00", tx_data); end
    repeat (30) @(negedge clk);
    checks++; if (start_cnt != s0)   begin failures++; $display("FAIL mid_no_start: got %0d starts want 0", start_cnt - s0); end
    checks++; if (level !== 5'd0)    begin failures++; $display("FAIL mid_level_later: got %0d want 0", level); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_ovf();
    test_stream();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
